// File: rtl/cursor_tracker.sv
// PS/2 mouse receiver: deframes serial bytes, assembles 3-byte packets
// and tracks a screen-clamped cursor position plus button state.
module cursor_tracker #(
  parameter int H       = 480,
  parameter int W       = 640,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [10:0] cursorX,
  output logic [10:0] cursorY,
  output logic        left_btn,
  output logic        right_btn,
  output logic        pkt_valid,
  output logic        frame_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic signed [11:0] XMAX = 12'(W - 1);
  localparam logic signed [11:0] YMAX = 12'(H - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} st_t;

  logic          c1_q, c2_q, c3_q, d1_q, d2_q;
  st_t           st_q, st_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [CW-1:0] to_q, to_d;
  logic          bv_q, bv_d;
  logic [7:0]    byte_q, byte_d;
  logic          ferr_q, ferr_d;
  logic [1:0]    idx_q, idx_d;
  logic [5:0]    hdr_q, hdr_d;
  logic [7:0]    b1_q, b1_d;
  logic [10:0]   x_q, x_d, y_q, y_d;
  logic          l_q, l_d, r_q, r_d;
  logic          pv_q, pv_d;

  logic              fall, bit_in;
  logic signed [11:0] nx, ny;
  logic [10:0]        cx, cy;

  assign fall   = c3_q & ~c2_q;
  assign bit_in = d2_q;

  // hdr_q = {Yovf, Xovf, Ysign, Xsign, R, L}
  always_comb begin
    nx = {1'b0, x_q} + {{4{hdr_q[2]}}, b1_q};
    ny = {1'b0, y_q} - {{4{hdr_q[3]}}, byte_q};
    if (nx[11])         cx = '0;
    else if (nx > XMAX) cx = XMAX[10:0];
    else                cx = nx[10:0];
    if (ny[11])         cy = '0;
    else if (ny > YMAX) cy = YMAX[10:0];
    else                cy = ny[10:0];
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    par_d  = par_q;
    to_d   = '0;
    bv_d   = 1'b0;
    byte_d = byte_q;
    ferr_d = 1'b0;
    if (st_q != IDLE && !fall && to_q == CW'(TIMEOUT)) begin
      st_d   = IDLE;
      ferr_d = 1'b1;
    end else begin
      if (st_q != IDLE && !fall) to_d = to_q + 1'b1;
      if (fall) begin
        unique case (st_q)
          IDLE: begin
            if (!bit_in) begin
              st_d  = DATA;
              cnt_d = '0;
            end
          end
          DATA: begin
            sh_d  = {bit_in, sh_q[7:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == 3'd7) st_d = PARITY;
          end
          PARITY: begin
            par_d = (^sh_q) ^ bit_in;
            st_d  = STOP;
          end
          STOP: begin
            st_d = IDLE;
            if (bit_in && par_q) begin
              bv_d   = 1'b1;
              byte_d = sh_q;
            end else begin
              ferr_d = 1'b1;
            end
          end
          default: st_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    idx_d = idx_q;
    hdr_d = hdr_q;
    b1_d  = b1_q;
    x_d   = x_q;
    y_d   = y_q;
    l_d   = l_q;
    r_d   = r_q;
    pv_d  = 1'b0;
    if (ferr_q) begin
      idx_d = '0;
    end else if (bv_q) begin
      unique case (idx_q)
        2'd0: begin
          // bit3 is always set in a real header; anything else is a resync
          if (byte_q[3]) begin
            hdr_d = {byte_q[7:4], byte_q[1:0]};
            idx_d = 2'd1;
          end
        end
        2'd1: begin
          b1_d  = byte_q;
          idx_d = 2'd2;
        end
        2'd2: begin
          idx_d = '0;
          pv_d  = 1'b1;
          l_d   = hdr_q[0];
          r_d   = hdr_q[1];
          if (!hdr_q[4]) x_d = cx;
          if (!hdr_q[5]) y_d = cy;
        end
        default: idx_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c1_q   <= 1'b1;
      c2_q   <= 1'b1;
      c3_q   <= 1'b1;
      d1_q   <= 1'b1;
      d2_q   <= 1'b1;
      st_q   <= IDLE;
      cnt_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      to_q   <= '0;
      bv_q   <= 1'b0;
      byte_q <= '0;
      ferr_q <= 1'b0;
      idx_q  <= '0;
      hdr_q  <= '0;
      b1_q   <= '0;
      x_q    <= 11'(W / 2);
      y_q    <= 11'(H / 2);
      l_q    <= 1'b0;
      r_q    <= 1'b0;
      pv_q   <= 1'b0;
    end else begin
      c1_q   <= PS2_CLK;
      c2_q   <= c1_q;
      c3_q   <= c2_q;
      d1_q   <= PS2_DAT;
      d2_q   <= d1_q;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      to_q   <= to_d;
      bv_q   <= bv_d;
      byte_q <= byte_d;
      ferr_q <= ferr_d;
      idx_q  <= idx_d;
      hdr_q  <= hdr_d;
      b1_q   <= b1_d;
      x_q    <= x_d;
      y_q    <= y_d;
      l_q    <= l_d;
      r_q    <= r_d;
      pv_q   <= pv_d;
    end
  end

  assign cursorX   = x_q;
  assign cursorY   = y_q;
  assign left_btn  = l_q;
  assign right_btn = r_q;
  assign pkt_valid = pv_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_cursor_tracker.sv
// Directed bench for cursor_tracker: bit-bangs PS/2 frames and checks
// cursor, buttons and pulse counts against hand-computed values.
module tb_cursor_tracker;

  localparam int HALF = 8;
  localparam int TO   = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DAT = 1'b1;
  logic [10:0] cursorX, cursorY;
  logic        left_btn, right_btn, pkt_valid, frame_err;

  int total = 0;
  int bad   = 0;
  int pv_n  = 0;
  int fe_n  = 0;

  cursor_tracker #(.H(480), .W(640), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .cursorX(cursorX), .cursorY(cursorY),
    .left_btn(left_btn), .right_btn(right_btn),
    .pkt_valid(pkt_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pkt_valid) pv_n++;
    if (frame_err) fe_n++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    repeat (HALF) @(posedge clk);
    #1 PS2_CLK = 1'b0;
    repeat (HALF) @(posedge clk);
    #1 PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic badpar);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ badpar, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    PS2_DAT = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2);
    send_frame(b0, 1'b0);
    send_frame(b1, 1'b0);
    send_frame(b2, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_pos(input string tag, input int x, y, l, r);
    chk({tag, "_x"}, int'(cursorX), x);
    chk({tag, "_y"}, int'(cursorY), y);
    chk({tag, "_l"}, int'(left_btn), l);
    chk({tag, "_r"}, int'(right_btn), r);
  endtask

  int pv0, fe0, ex;

  initial begin
    do_reset();
    @(negedge clk);
    chk_pos("rst", 320, 240, 0, 0);
    chk("rst_pv", int'(pkt_valid), 0);
    chk("rst_fe", int'(frame_err), 0);

    pv0 = pv_n;
    send_pkt(8'h09, 8'h05, 8'h03);
    chk("p1_pv", pv_n - pv0, 1);
    chk_pos("p1", 325, 237, 1, 0);

    do_reset();
    pv0 = pv_n;
    for (int k = 0; k < 40; k++) begin
      send_pkt(8'h18, 8'hF6, 8'h00);
      ex = 320 - 10 * (k + 1);
      if (ex < 0) ex = 0;
      chk($sformatf("left%0d", k), int'(cursorX), ex);
    end
    chk("left_pv", pv_n - pv0, 40);
    chk("left_y", int'(cursorY), 240);

    do_reset();
    send_pkt(8'h28, 8'h00, 8'h80);
    chk_pos("dn1", 320, 368, 0, 0);
    send_pkt(8'h28, 8'h00, 8'h80);
    chk_pos("dn2", 320, 479, 0, 0);

    do_reset();
    send_pkt(8'h49, 8'h7F, 8'h02);
    chk_pos("xovf", 320, 238, 1, 0);

    do_reset();
    pv0 = pv_n;
    fe0 = fe_n;
    send_frame(8'h08, 1'b0);
    send_frame(8'h01, 1'b1);
    repeat (10) @(posedge clk);
    chk("par_fe", fe_n - fe0, 1);
    chk("par_pv", pv_n - pv0, 0);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk("par_pv2", pv_n - pv0, 1);
    chk_pos("par", 321, 239, 0, 0);

    do_reset();
    pv0 = pv_n;
    fe0 = fe_n;
    send_frame(8'h00, 1'b0);
    repeat (10) @(posedge clk);
    chk("stray_pv", pv_n - pv0, 0);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk("stray_pv2", pv_n - pv0, 1);
    chk("stray_fe", fe_n - fe0, 0);
    chk_pos("stray", 321, 239, 0, 0);

    do_reset();
    pv0 = pv_n;
    fe0 = fe_n;
    for (int i = 0; i < 5; i++) ps2_bit(1'(i == 1));
    PS2_DAT = 1'b1;
    repeat (TO + 50) @(posedge clk);
    chk("to_fe", fe_n - fe0, 1);
    chk("to_pv", pv_n - pv0, 0);
    send_pkt(8'h09, 8'h05, 8'h03);
    chk("to_pv2", pv_n - pv0, 1);
    chk_pos("to", 325, 237, 1, 0);

    do_reset();
    send_pkt(8'h0B, 8'h05, 8'h03);
    chk_pos("pre", 325, 237, 1, 1);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    do_reset();
    @(negedge clk);
    chk_pos("mrst", 320, 240, 0, 0);
    send_pkt(8'h08, 8'h01, 8'h01);
    chk_pos("mrst2", 321, 239, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
